instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 16 +
 rtl/if_id_reg.sv | 33 +++
 rtl/instruction_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BUBBLE = 2'd0,
    RUN    = 2'd1,
    HALT   = 2'd2
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP               = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] PC_STEP           = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush squashes to a bubble, hold freezes, load captures.
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pcplus4_d,
  output logic [XLEN-1:0] instr_q,
  output logic [XLEN-1:0] pcplus4_q,
  output logic            valid_q
);

  // A bubble keeps the last PC+4 so only the payload and valid bit change.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= NOP;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (load && !hold) begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, BUBBLE/RUN/HALT control and IF/ID register.
// Optional IF_PERF_COUNTERS_EN adds FetchCount/StallCount outputs.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        Halted
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect;
  logic            halt_hit;
  logic            ifid_load;
  logic            ifid_flush;
  logic            unused_target_bits;

  assign pc_plus4    = pc_q + PC_STEP;
  assign redirect    = Jump | PCSrc;
  assign redirect_pc = Jump ? {JumpTarget[31:2], 2'b00} : {BranchTarget[31:2], 2'b00};
  assign halt_hit    = (IMemInstruction == HALT_WORD);
  assign unused_target_bits = ^{JumpTarget[1:0], BranchTarget[1:0]};

  assign IMemAddress = pc_q;
  assign Halted      = (state_q == HALT);

  // State and PC registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= BUBBLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUBBLE: state_d = RUN;
      RUN:    if (!redirect && !Flush && !Stall && halt_hit) state_d = HALT;
      HALT:   if (redirect) state_d = RUN;
      default: state_d = BUBBLE;
    endcase
  end

  // PC update and IF/ID controls, priority Jump > PCSrc > Flush > Stall > advance
  always_comb begin
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
        end else if (Flush) begin
          pc_d       = pc_plus4;
          ifid_flush = 1'b1;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (halt_hit) begin
          ifid_flush = 1'b1;
        end else begin
          pc_d      = pc_plus4;
          ifid_load = 1'b1;
        end
      end
      HALT: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
        end else if (Flush) begin
          ifid_flush = 1'b1;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk       (Clk),
    .rst       (Rst),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .hold      (Stall),
    .instr_d   (IMemInstruction),
    .pcplus4_d (pc_plus4),
    .instr_q   (IF_ID_Instruction),
    .pcplus4_q (IF_ID_PCPlus4),
    .valid_q   (IF_ID_Valid)
  );

`ifdef IF_PERF_COUNTERS_EN
  // Performance counters, free-running modulo 2^32
  always_ff @(posedge Clk) begin
    if (Rst) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (ifid_load) FetchCount <= FetchCount + 32'd1;
      if ((state_q == RUN) && Stall && !redirect) StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule
